// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator.
// Holds the default 640x480@60 timing, the counter widths, the sync bundle
// type carried through the render-latency delay line, and its reset value.
package vga_timing_pkg;

  // Counter and comparison widths. x/y leave on 10 bits. Window compares use
  // one extra bit so a window that ends exactly at 1024 is still handled.
  localparam int CNT_W = 10;
  localparam int CMP_W = 11;
  localparam int DIV_W = 4;

  // Default 640x480@60 timing, in pixels and lines.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Sync bundle. hs and vs are active-low.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // Blanked, no sync pulse.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

  // Total pixels per line.
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Total lines per frame.
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle sent from vga_timing_gen to its consumers.
//   x, y        : current pixel coordinates (h_cnt, v_cnt)
//   pix_tick    : high in the clk cycle before the counters advance
//   de          : undelayed active-area flag
//   frame_start : one-clk pulse on the first cycle of each frame
//   hsync_o     : active-low hsync, delayed by the render latency
//   vsync_o     : active-low vsync, delayed by the render latency
//   de_o        : data enable, delayed by the render latency
// master = generator side, slave = consumer side.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             pix_tick;
  logic             de;
  logic             frame_start;
  logic             hsync_o;
  logic             vsync_o;
  logic             de_o;

  modport master (
    output x, y, pix_tick, de, frame_start, hsync_o, vsync_o, de_o
  );

  modport slave (
    input x, y, pix_tick, de, frame_start, hsync_o, vsync_o, de_o
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth delay line for the {hs, vs, de} sync bundle.
// The line advances every clk, so sync lines up with a registered pixel
// pipeline of the same depth. With DEPTH = 0 the bundle passes straight through.
//   clk   : clock
//   reset : synchronous, active-high; every stage loads SYNC_IDLE
//   d     : bundle in
//   q     : bundle out, DEPTH clk later
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  reset,
  input  sync_t d,
  output sync_t q
);

  if (DEPTH == 0) begin : g_wire
    // Pass-through build: clk and reset are not used.
    logic unused_s;
    assign unused_s = clk ^ reset;
    assign q        = d;
  end else begin : g_pipe
    sync_t stage_r [DEPTH];

    // Shift register. Reset fills every stage with the idle bundle.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_r[i] <= SYNC_IDLE;
        end
      end else begin
        stage_r[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_r[i] <= stage_r[i-1];
        end
      end
    end

    assign q = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. It sits directly upstream of ui_render.
// A clk divider sets the pixel rate. h_cnt and v_cnt count pixels and lines.
// Decodes of these counters give de, frame_start and the raw sync.
// The sync bundle is delayed by RENDER_LAT clk, so it lines up with the
// registered r/g/b that the renderer produces.
//   clk   : system clock
//   reset : synchronous, active-high
//   vif   : master side of vga_timing_gen_if
//           (x, y, pix_tick, de, frame_start, hsync_o, vsync_o, de_o)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int RENDER_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CMP_W-1:0] H_ACT_C  = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] V_ACT_C  = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0] HS_BEG_C = CMP_W'(H_ACTIVE + H_FP);
  localparam logic [CMP_W-1:0] HS_END_C = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] VS_BEG_C = CMP_W'(V_ACTIVE + V_FP);
  localparam logic [CMP_W-1:0] VS_END_C = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_r;
  logic [CNT_W-1:0] h_cnt_r;
  logic [CNT_W-1:0] v_cnt_r;
  logic [CMP_W-1:0] h_ext_s;
  logic [CMP_W-1:0] v_ext_s;
  logic             pix_tick_s;
  logic             frame_start_s;
  sync_t            raw_s;
  sync_t            dly_s;

  assign pix_tick_s = (div_cnt_r == DIV_LAST);
  assign h_ext_s    = {1'b0, h_cnt_r};
  assign v_ext_s    = {1'b0, v_cnt_r};

  // Pixel divider and raster counters. Reset takes priority, so a line in
  // progress is dropped, not finished.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= 4'd0;
      h_cnt_r   <= 10'd0;
      v_cnt_r   <= 10'd0;
    end else if (pix_tick_s) begin
      div_cnt_r <= 4'd0;
      if (h_cnt_r == H_LAST) begin
        h_cnt_r <= 10'd0;
        if (v_cnt_r == V_LAST) begin
          v_cnt_r <= 10'd0;
        end else begin
          v_cnt_r <= v_cnt_r + 10'd1;
        end
      end else begin
        h_cnt_r <= h_cnt_r + 10'd1;
      end
    end else begin
      div_cnt_r <= div_cnt_r + 4'd1;
    end
  end

  // Raw decodes of the counter state: active area, sync windows, frame start.
  always_comb begin
    raw_s         = SYNC_IDLE;
    raw_s.de      = (h_ext_s < H_ACT_C) && (v_ext_s < V_ACT_C);
    raw_s.hs      = !((h_ext_s >= HS_BEG_C) && (h_ext_s < HS_END_C));
    raw_s.vs      = !((v_ext_s >= VS_BEG_C) && (v_ext_s < VS_END_C));
    frame_start_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0) && (div_cnt_r == 4'd0);
  end

  sync_delay_line #(
    .DEPTH (RENDER_LAT)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .d     (raw_s),
    .q     (dly_s)
  );

  assign vif.x           = h_cnt_r;
  assign vif.y           = v_cnt_r;
  assign vif.pix_tick    = pix_tick_s;
  assign vif.de          = raw_s.de;
  assign vif.frame_start = frame_start_s;
  assign vif.hsync_o     = dly_s.hs;
  assign vif.vsync_o     = dly_s.vs;
  assign vif.de_o        = dly_s.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Three builds use small rasters so
// each frame is short:
//   a: CLK_DIV 3, render latency 2
//   b: CLK_DIV 1, render latency 1
//   c: CLK_DIV 4, pass-through (latency 0)
// The expected outputs come from a model of elapsed clk cycles since reset.
// The model uses plain division and modulo on that count.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int cd; int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb; int lat;
  } cfg_t;

  typedef struct {
    int x; int y; int pt; int de; int fs; int hso; int vso; int deo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   t;
  int   vectors;
  int   miscompares;

  cfg_t cfg_a = '{cd: 3, ha: 8, hf: 2, hs: 3, hb: 2, va: 5, vf: 1, vs: 2, vb: 2, lat: 2};
  cfg_t cfg_b = '{cd: 1, ha: 8, hf: 2, hs: 3, hb: 2, va: 5, vf: 1, vs: 2, vb: 2, lat: 1};
  cfg_t cfg_c = '{cd: 4, ha: 6, hf: 1, hs: 2, hb: 1, va: 4, vf: 1, vs: 1, vb: 1, lat: 0};

  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .RENDER_LAT(2)
  ) dut_a (.clk(clk), .reset(reset), .vif(if_a));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .RENDER_LAT(1)
  ) dut_b (.clk(clk), .reset(reset), .vif(if_b));

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .RENDER_LAT(0)
  ) dut_c (.clk(clk), .reset(reset), .vif(if_c));

  // Expected outputs t clk cycles after the last reset edge.
  // At time t the raster position is pixel floor(t/CLK_DIV) of the frame.
  // The delayed sync shows the raw decode from lat cycles earlier. Before
  // that point it shows the idle bundle.
  function automatic exp_t model(input cfg_t c, input int t_in);
    exp_t e;
    int   htot;
    int   vtot;
    int   pix;
    int   dpix;
    int   dx;
    int   dy;
    htot  = c.ha + c.hf + c.hs + c.hb;
    vtot  = c.va + c.vf + c.vs + c.vb;
    pix   = (t_in / c.cd) % (htot * vtot);
    e.x   = pix % htot;
    e.y   = pix / htot;
    e.pt  = ((t_in % c.cd) == (c.cd - 1)) ? 1 : 0;
    e.fs  = ((t_in % (c.cd * htot * vtot)) == 0) ? 1 : 0;
    e.de  = ((e.x < c.ha) && (e.y < c.va)) ? 1 : 0;
    if (t_in < c.lat) begin
      e.hso = 1;
      e.vso = 1;
      e.deo = 0;
    end else begin
      dpix  = ((t_in - c.lat) / c.cd) % (htot * vtot);
      dx    = dpix % htot;
      dy    = dpix / htot;
      e.hso = ((dx >= c.ha + c.hf) && (dx < c.ha + c.hf + c.hs)) ? 0 : 1;
      e.vso = ((dy >= c.va + c.vf) && (dy < c.va + c.vf + c.vs)) ? 0 : 1;
      e.deo = ((dx < c.ha) && (dy < c.va)) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input int expv);
    logic [9:0] e;
    e = 10'(expv);
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, e);
    end
  endtask

  task automatic check_dut(input string name, input cfg_t c,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic pt, input logic de, input logic fs,
                           input logic hso, input logic vso, input logic deo);
    exp_t e;
    e = model(c, t);
    vectors++;
    chk({name, ".x"}, x, e.x);
    chk({name, ".y"}, y, e.y);
    chk({name, ".pix_tick"}, {9'd0, pt}, e.pt);
    chk({name, ".de"}, {9'd0, de}, e.de);
    chk({name, ".frame_start"}, {9'd0, fs}, e.fs);
    chk({name, ".hsync_o"}, {9'd0, hso}, e.hso);
    chk({name, ".vsync_o"}, {9'd0, vso}, e.vso);
    chk({name, ".de_o"}, {9'd0, deo}, e.deo);
  endtask

  // One clk: advance the model's cycle count (a reset edge restarts it).
  // Then check all three builds on the falling edge.
  task automatic step();
    @(posedge clk);
    if (reset) t = 0;
    else       t = t + 1;
    @(negedge clk);
    check_dut("a", cfg_a, if_a.x, if_a.y, if_a.pix_tick, if_a.de, if_a.frame_start,
              if_a.hsync_o, if_a.vsync_o, if_a.de_o);
    check_dut("b", cfg_b, if_b.x, if_b.y, if_b.pix_tick, if_b.de, if_b.frame_start,
              if_b.hsync_o, if_b.vsync_o, if_b.de_o);
    check_dut("c", cfg_c, if_c.x, if_c.y, if_c.pix_tick, if_c.de, if_c.frame_start,
              if_c.hsync_o, if_c.vsync_o, if_c.de_o);
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    t           = 0;

    // Reset for three edges; the state must stay at the reset values throughout.
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Run freely over several full frames of every build (line and frame wraps).
    repeat (1000) step();

    // Reset mid-frame on build a, at pixel (9, 3) with div_cnt 2.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat ((3 * 15 + 9) * 3 + 2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Random run lengths, each followed by a reset of random length.
    for (int seg = 0; seg < 20; seg++) begin
      n = $urandom_range(1, 500);
      repeat (n) step();
      reset = 1'b1;
      n = $urandom_range(1, 3);
      repeat (n) step();
      reset = 1'b0;
    end

    repeat (1000) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that sits directly upstream of ui_render.
- Produces the pixel coordinates (x, y) that ui_render consumes, plus the sync and data-enable signals.
- Sync/enable outputs are delayed by RENDER_LAT clk cycles, so they line up with the registered r/g/b from ui_render at the VGA pins.
- Default timing: 640x480@60, pixel rate = clk / CLK_DIV.

Parameters:
- CLK_DIV, 4: clk cycles per pixel (1 means one pixel every cycle); range 1..16.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- RENDER_LAT, 1: clk-cycle delay applied to hsync_o/vsync_o/de_o; 0 means pass-through.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- x  output  10  horizontal counter h_cnt (0..H_TOTAL-1); feeds ui_render.x.
- y  output  10  vertical counter v_cnt (0..V_TOTAL-1); feeds ui_render.y.
- pix_tick  output  1  high in the clk cycle before the counters advance.
- de  output  1  undelayed active-area flag.
- frame_start  output  1  one-clk pulse on the first cycle of each frame.
- hsync_o  output  1  active-low hsync, delayed by RENDER_LAT.
- vsync_o  output  1  active-low vsync, delayed by RENDER_LAT.
- de_o  output  1  data enable, delayed by RENDER_LAT.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Derived constants: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (default 800); V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (default 525). Both must be ≤ 1024; elaboration-time assertion otherwise.
- State registers: div_cnt (0..CLK_DIV-1), h_cnt, v_cnt, and the delay line.
- pix_tick = (div_cnt == CLK_DIV-1). Combinational decode of state.
- div_cnt increments every clk and wraps to 0 on pix_tick.
- On pix_tick:
  - h_cnt increments.
  - At h_cnt == H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt == V_TOTAL-1 with h wrap, v_cnt wraps to 0.
- Counters hold their value between ticks, so x/y are stable for CLK_DIV cycles.
- Decodes, all combinational from the counter registers:
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_raw = 0 iff h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); default window [656, 752).
  - vs_raw = 0 iff v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); default window [490, 492).
  - frame_start = (h_cnt == 0 && v_cnt == 0 && div_cnt == 0).
- Delay line:
  - RENDER_LAT register stages on {hs_raw, vs_raw, de}, advancing every clk (not only on pix_tick).
  - This matches ui_render's 1-clk output register.
  - RENDER_LAT = 0: outputs equal the raw decodes.
- Reset (synchronous, wins over all other updates):
  - div_cnt = h_cnt = v_cnt = 0.
  - Every delay stage loads hsync = 1, vsync = 1, de = 0.
- Output values in the first cycle after reset:
  - x = 0, y = 0, de = 1, frame_start = 1, pix_tick = (CLK_DIV == 1).
  - hsync_o = 1, vsync_o = 1, de_o = 0 (when RENDER_LAT ≥ 1).
- Reset mid-frame: takes effect at the next edge regardless of div_cnt; no partial line is completed.
- Simultaneous h wrap and v wrap on the same tick: both counters go to 0 on that edge.

Decomposition:
- Shared package vga_timing_pkg:
  - Default timing constants (H_*/V_* defaults, H_TOTAL/V_TOTAL functions).
  - Packed struct sync_t {hs, vs, de}.
  - Reset constant SYNC_IDLE = {1, 1, 0}.
- One sub-module: sync_delay_line.
  - Parameter DEPTH; input clk, reset, sync_t d; output sync_t q.
  - DEPTH = 0 generates a wire.

Test Plan:
- Reset release, CLK_DIV = 4:
  - frame_start = 1 for exactly one clk; x = 0, y = 0.
  - x becomes 1 after 4 clk edges, becomes 2 after 8.
  - pix_tick is high on clk 3, 7, 11, …
- Line wrap, CLK_DIV = 4: at h_cnt = 799 with pix_tick → next x = 0, y incremented. hsync_o is low for exactly 384 clk, starting 1 clk after x reaches 656.
- Frame wrap, CLK_DIV = 4:
  - v = 524, h = 799 tick → x = 0, y = 0.
  - frame_start period = 1,680,000 clk.
  - vsync_o low for exactly 6,400 clk, starting 1 clk after y reaches 490.
- Active area, CLK_DIV = 1, RENDER_LAT = 1:
  - de_o high for 307,200 clk per frame.
  - de_o(t) == de(t-1) on every cycle.
  - Feeding x/y into ui_render: de_o first rises on the same edge r/g/b first shows sky colour 0x87CEEB at (0, 0).
- Reset asserted at x = 300, y = 200, div_cnt = 2: next cycle x = 0, y = 0, hsync_o = 1, vsync_o = 1, de_o = 0, frame_start = 1.
- RENDER_LAT = 0 and RENDER_LAT = 3 builds: hsync_o/de_o equal the raw decodes delayed by 0 and 3 clk respectively over a full frame.
